// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display between
// NUM_REQ requesters, holding each granted frame for a minimum number of scan ticks.
module seven_seg_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DIV_RATIO  = 100000,
  parameter int HOLD_TICKS = 500,
  localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [4*NUM_REQ-1:0]    req_dp,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    clear,
  output logic [15:0]             disp_data,
  output logic [3:0]              disp_dp,
  output logic [OWN_W-1:0]        disp_owner,
  output logic                    disp_blank,
  output logic                    hold_done
);

  localparam int DIV_W = $clog2(DIV_RATIO);
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
  localparam logic [OWN_W-1:0] LAST_REQ = OWN_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        disp_data_q, disp_data_d;
  logic [3:0]         disp_dp_q, disp_dp_d;
  logic [OWN_W-1:0]   disp_owner_q, disp_owner_d;
  logic               disp_blank_q, disp_blank_d;

  logic               tick;
  logic               accepting;
  logic               grant_found;
  logic               hi_found;
  logic [OWN_W-1:0]   hi_idx;
  logic [OWN_W-1:0]   low_idx;
  logic [OWN_W-1:0]   grant_idx;
  logic               xfer;
  logic [15:0]        sel_data;
  logic [3:0]         sel_dp;

  assign tick      = (div_q == DIV_LAST);
  assign accepting = (state_q == IDLE) || (state_q == HOLD && hold_cnt_q == HOLD_MAX);
  assign xfer      = accepting && !clear && grant_found;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    hi_found    = 1'b0;
    hi_idx      = '0;
    low_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        low_idx     = OWN_W'(i);
        if (OWN_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = OWN_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : low_idx;
  end

  always_comb begin
    sel_data = '0;
    sel_dp   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OWN_W'(i) == grant_idx) begin
        sel_data = req_data[16*i +: 16];
        sel_dp   = req_dp[4*i +: 4];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer && !reset) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + 1'b1;
    hold_cnt_d   = hold_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_owner_d = disp_owner_q;
    disp_blank_d = disp_blank_q;

    if (clear) begin
      state_d      = IDLE;
      disp_blank_d = 1'b1;
      hold_cnt_d   = '0;
    end else if (xfer) begin
      state_d      = HOLD;
      hold_cnt_d   = '0;
      disp_data_d  = sel_data;
      disp_dp_d    = sel_dp;
      disp_owner_d = grant_idx;
      disp_blank_d = 1'b0;
      rr_ptr_d     = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
    end else if (state_q == HOLD && tick && hold_cnt_q < HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_owner_q <= '0;
      disp_blank_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      hold_cnt_q   <= hold_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_owner_q <= disp_owner_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_dp    = disp_dp_q;
  assign disp_owner = disp_owner_q;
  assign disp_blank = disp_blank_q;
  assign hold_done  = accepting;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Self-checking bench for seven_seg_arbiter with DIV_RATIO=4, HOLD_TICKS=3, NUM_REQ=2:
// vector tables for arbitration, a frame scoreboard, and hand-written reset/clear sequences.
module tb_seven_seg_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int DIV_RATIO  = 4;
  localparam int HOLD_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_dp;
  logic [1:0]  req_ready;
  logic        clear;
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  logic        disp_owner;
  logic        disp_blank;
  logic        hold_done;

  seven_seg_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DIV_RATIO  (DIV_RATIO),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_dp     (req_dp),
    .req_ready  (req_ready),
    .clear      (clear),
    .disp_data  (disp_data),
    .disp_dp    (disp_dp),
    .disp_owner (disp_owner),
    .disp_blank (disp_blank),
    .hold_done  (hold_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        owner;
  } frame_t;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [3:0]  dp0;
    logic [3:0]  dp1;
    logic [1:0]  exp_ready;
    logic        exp_owner;
  } vec_t;

  typedef struct {
    logic       clr;
    logic [1:0] valid;
    logic [1:0] exp_ready;
  } comb_t;

  frame_t sb[$];
  vec_t   vecs[5];
  comb_t  combs[6];
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic owner, input logic [15:0] data, input logic [3:0] dp);
    frame_t f;
    f.owner = owner;
    f.data  = data;
    f.dp    = dp;
    sb.push_back(f);
  endtask

  task automatic compare_frame(input string name);
    frame_t f;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got a frame with no expected entry queued", name);
    end else begin
      f = sb.pop_front();
      check($sformatf("%s_data", name), disp_data, f.data);
      check($sformatf("%s_dp", name), disp_dp, f.dp);
      check($sformatf("%s_owner", name), disp_owner, f.owner);
      check($sformatf("%s_blank", name), disp_blank, 1'b0);
    end
  endtask

  task automatic wait_accept(output int n);
    n = 0;
    while (hold_done !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int changed;
    int both;

    vecs[0] = '{16'hA001, 16'hB001, 4'h1, 4'h8, 2'b01, 1'b0};
    vecs[1] = '{16'hA002, 16'hB002, 4'h2, 4'h4, 2'b10, 1'b1};
    vecs[2] = '{16'hA003, 16'hB003, 4'h3, 4'hC, 2'b01, 1'b0};
    vecs[3] = '{16'hA004, 16'hB004, 4'h4, 4'hD, 2'b10, 1'b1};
    vecs[4] = '{16'hA005, 16'hB005, 4'h5, 4'hE, 2'b01, 1'b0};

    combs[0] = '{1'b0, 2'b11, 2'b10};
    combs[1] = '{1'b0, 2'b01, 2'b01};
    combs[2] = '{1'b0, 2'b00, 2'b00};
    combs[3] = '{1'b1, 2'b11, 2'b00};
    combs[4] = '{1'b1, 2'b10, 2'b00};
    combs[5] = '{1'b0, 2'b10, 2'b10};

    // Power-on reset with both requesters already offering.
    reset     = 1'b1;
    clear     = 1'b0;
    req_valid = 2'b11;
    req_data  = 32'h5555_AAAA;
    req_dp    = 8'hFF;
    #1;
    check("rst_blank", disp_blank, 1'b1);
    check("rst_data", disp_data, 16'h0);
    check("rst_dp", disp_dp, 4'h0);
    check("rst_owner", disp_owner, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    cyc();
    cyc();

    // First frame from IDLE, accepted combinationally in the same cycle.
    reset     = 1'b0;
    req_valid = 2'b01;
    req_data  = 32'h0000_1234;
    req_dp    = 8'h02;
    #1;
    check("t2_ready", req_ready, 2'b01);
    check("t2_idle_hold_done", hold_done, 1'b1);
    expect_frame(1'b0, 16'h1234, 4'h2);
    cyc();
    req_valid = 2'b00;
    compare_frame("t2_frame");
    check("t2_hold_done_low", hold_done, 1'b0);

    // Competing requester waits out the minimum hold (divider phase is known after reset).
    req_valid = 2'b10;
    req_data  = {16'hBEEF, 16'h1234};
    req_dp    = 8'h52;
    #1;
    check("t3_ready_blocked", req_ready, 2'b00);
    wait_accept(n);
    check("t3_hold_cycles", n, 11);
    check("t3_ready", req_ready, 2'b10);
    expect_frame(1'b1, 16'hBEEF, 4'h5);
    cyc();
    compare_frame("t3_frame");

    // Both requesters continuously valid: grants must alternate.
    both = 0;
    for (int v = 0; v < 5; v++) begin
      req_valid = 2'b11;
      req_data  = {vecs[v].d1, vecs[v].d0};
      req_dp    = {vecs[v].dp1, vecs[v].dp0};
      #1;
      n = 0;
      while (hold_done !== 1'b1 && n < 40) begin
        if (req_ready == 2'b11) both++;
        cyc();
        n++;
      end
      if (req_ready == 2'b11) both++;
      check($sformatf("t4_hold_cycles_%0d", v), n, 11);
      check($sformatf("t4_ready_%0d", v), req_ready, vecs[v].exp_ready);
      expect_frame(vecs[v].exp_owner,
                   vecs[v].exp_owner ? vecs[v].d1 : vecs[v].d0,
                   vecs[v].exp_owner ? vecs[v].dp1 : vecs[v].dp0);
      cyc();
      compare_frame($sformatf("t4_frame_%0d", v));
    end
    check("t4_never_both_ready", both, 0);

    // Frame from requester 1, then let it expire with nobody asking.
    req_valid = 2'b10;
    req_data  = {16'hC0DE, 16'hA005};
    req_dp    = 8'h95;
    #1;
    wait_accept(n);
    check("t5_hold_cycles", n, 11);
    check("t5_ready1", req_ready, 2'b10);
    expect_frame(1'b1, 16'hC0DE, 4'h9);
    cyc();
    req_valid = 2'b00;
    compare_frame("t5_frame1");
    changed = 0;
    for (int c = 0; c < 50; c++) begin
      cyc();
      if (disp_data !== 16'hC0DE || disp_blank !== 1'b0) changed++;
    end
    check("t5_frame_retained", changed, 0);
    check("t5_expired_accepting", hold_done, 1'b1);
    req_valid = 2'b01;
    req_data  = {16'hC0DE, 16'h0F0F};
    req_dp    = 8'h93;
    #1;
    check("t5_late_ready", req_ready, 2'b01);
    expect_frame(1'b0, 16'h0F0F, 4'h3);
    cyc();
    req_valid = 2'b00;
    compare_frame("t5_frame2");

    // clear wins over a handshake on the first accepting cycle.
    wait_accept(n);
    check("t6_hold_in_range", (n >= 9 && n <= 12), 1'b1);
    req_valid = 2'b10;
    req_data  = {16'h1111, 16'h0F0F};
    req_dp    = 8'h13;
    clear     = 1'b1;
    #1;
    check("t6_clear_blocks_ready", req_ready, 2'b00);
    cyc();
    check("t6_blank", disp_blank, 1'b1);
    check("t6_data_kept", disp_data, 16'h0F0F);
    check("t6_owner_kept", disp_owner, 1'b0);
    check("t6_idle_accepting", hold_done, 1'b1);
    // rr_ptr is 1 here; the last vector leaves a real offer for the coming edge.
    for (int k = 0; k < 6; k++) begin
      clear     = combs[k].clr;
      req_valid = combs[k].valid;
      #1;
      check($sformatf("t6_comb_%0d", k), req_ready, combs[k].exp_ready);
    end
    expect_frame(1'b1, 16'h1111, 4'h1);
    cyc();
    req_valid = 2'b00;
    compare_frame("t6_frame");

    // Asynchronous reset in the middle of a hold.
    #2;
    req_valid = 2'b11;
    reset     = 1'b1;
    #1;
    check("t1_blank", disp_blank, 1'b1);
    check("t1_data", disp_data, 16'h0);
    check("t1_owner", disp_owner, 1'b0);
    check("t1_ready", req_ready, 2'b00);
    cyc();
    reset     = 1'b0;
    req_valid = 2'b11;
    req_data  = {16'h3333, 16'h2222};
    req_dp    = 8'h76;
    #1;
    check("t1_hold_done", hold_done, 1'b1);
    check("t1_ready_after", req_ready, 2'b01);
    expect_frame(1'b0, 16'h2222, 4'h6);
    cyc();
    req_valid = 2'b00;
    compare_frame("t1_frame");
    wait_accept(n);
    check("t1_hold_cycles", n, 11);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d unconsumed frames expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
